// File: rtl/instr_sequencer_pkg.sv
// mc14500_pkg: opcode map and width constants shared by the instruction sequencer files
package mc14500_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        NOPO = 4'h0, LD, LDC, AND, ANDC, OR, ORC, XNOR,
        STO, STOC, IEN, OEN, JMP, RTN, SKZ, NOPF
    } opcode_t;

    function automatic logic is_alu_op(opcode_t op);
        return op != NOPO && op < JMP;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program word in, ALU strobe / PC load / flag pins out
interface instr_sequencer_if #(
    parameter int SIZE_LOG = 8,
    parameter int IO_W     = 3
);
    import mc14500_pkg::*;

    localparam int OPD_W = SIZE_LOG > IO_W ? SIZE_LOG : IO_W;

    logic [OPCODE_W+OPD_W-1:0] instr;
    logic [SIZE_LOG-1:0]       pc_in;
    logic                      rr;
    logic                      exec_en;
    logic [OPCODE_W-1:0]       opcode;
    logic [IO_W-1:0]           io_addr;
    logic                      pc_write;
    logic [SIZE_LOG-1:0]       pc_target;
    logic                      flag_jmp;
    logic                      flag_rtn;
    logic                      flag_0;
    logic                      flag_f;

    modport master (
        input  instr, pc_in, rr,
        output exec_en, opcode, io_addr, pc_write, pc_target,
               flag_jmp, flag_rtn, flag_0, flag_f
    );

    modport slave (
        output instr, pc_in, rr,
        input  exec_en, opcode, io_addr, pc_write, pc_target,
               flag_jmp, flag_rtn, flag_0, flag_f
    );

endinterface

// File: rtl/instr_sequencer_ret_stack.sv
// ret_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_inc, ptr_dec;
    logic [CW-1:0] cnt_q;

    assign ptr_inc = ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = ptr_q == '0 ? PW'(DEPTH - 1) : ptr_q - PW'(1);
    assign data_o  = mem_q[ptr_dec];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);

    // ptr_q is the next free slot; the count saturates so overwrites keep it at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_inc;
            cnt_q <= full_o ? cnt_q : cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // entry storage needs no reset; the count alone decides validity
    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: decodes program words into ALU strobe, PC load and flag pulses; RET_STACK_EN adds a return-address stack
module instr_sequencer
    import mc14500_pkg::*;
#(
    parameter int SIZE_LOG    = 8,
    parameter int IO_W        = 3,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.master bus
);
    localparam int OPD_W = SIZE_LOG > IO_W ? SIZE_LOG : IO_W;

    typedef enum logic {RUN, SKIP} state_t;

    state_t              state_q, state_d;
    opcode_t             op;
    logic [OPD_W-1:0]    operand;
    logic [SIZE_LOG-1:0] pc_inc, st_top;
    logic                squash, push, pop, st_empty;

    assign op      = opcode_t'(bus.instr[OPCODE_W+OPD_W-1 -: OPCODE_W]);
    assign operand = bus.instr[OPD_W-1:0];
    assign pc_inc  = bus.pc_in + SIZE_LOG'(1);
    assign squash  = state_q == SKIP || rst;
    assign push    = !squash && op == JMP;
    assign pop     = !squash && op == RTN && !st_empty;

`ifdef RET_STACK_EN
    ret_stack #(.W(SIZE_LOG), .DEPTH(STACK_DEPTH)) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .data_o  (st_top),
        .empty_o (st_empty),
        .full_o  ()
    );
`else
    assign st_empty = 1'b1;
    assign st_top   = '0;
`endif

    // skip register; a skipped slot never re-arms it
    always_ff @(posedge clk) begin
        state_q <= rst ? RUN : state_d;
    end

    // decode is purely combinational so the PC sees pc_write/pc_target before its falling edge
    always_comb begin
        state_d       = (!squash && ((op == RTN && !pop) || (op == SKZ && !bus.rr))) ? SKIP : RUN;
        bus.opcode    = op;
        bus.io_addr   = operand[IO_W-1:0];
        bus.exec_en   = !squash && is_alu_op(op);
        bus.pc_write  = push || pop;
        bus.pc_target = push ? operand[SIZE_LOG-1:0] : pop ? st_top : pc_inc;
        bus.flag_jmp  = push;
        bus.flag_rtn  = !squash && op == RTN;
        bus.flag_0    = !squash && op == NOPO;
        bus.flag_f    = !squash && op == NOPF;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed plus random program words checked against a rule-level model (RET_STACK_EN aware)
module tb_instr_sequencer;
    import mc14500_pkg::*;

    localparam int SIZE_LOG    = 8;
    localparam int IO_W        = 3;
    localparam int STACK_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic       skip_m = 1'b0;
    logic [7:0] stk_m[$];

    instr_sequencer_if #(.SIZE_LOG(SIZE_LOG), .IO_W(IO_W)) bus ();

    instr_sequencer #(.SIZE_LOG(SIZE_LOG), .IO_W(IO_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one instruction slot: drive after the falling edge, check, then advance the model past the rising edge
    task automatic step(input logic r, input logic [3:0] op, input logic [7:0] opd,
                        input logic [7:0] pc, input logic rr_v);
        bit         sq, stacked, popm, jmpm, nskip;
        logic [7:0] tgt;
        @(negedge clk);
        rst       = r;
        bus.instr = {op, opd};
        bus.pc_in = pc;
        bus.rr    = rr_v;
        #1;
        sq = skip_m || r;
`ifdef RET_STACK_EN
        stacked = 1'b1;
`else
        stacked = 1'b0;
`endif
        jmpm = !sq && op == 4'hC;
        popm = stacked && !sq && op == 4'hD && stk_m.size() > 0;
        tgt  = jmpm ? opd : popm ? stk_m[stk_m.size()-1] : 8'((int'(pc) + 1) % 256);
        check("exec_en", 32'(bus.exec_en), 32'(!sq && op >= 4'h1 && op <= 4'hB));
        check("opcode", 32'(bus.opcode), 32'(op));
        check("io_addr", 32'(bus.io_addr), 32'(opd % 8));
        check("pc_write", 32'(bus.pc_write), 32'(jmpm || popm));
        check("pc_target", 32'(bus.pc_target), 32'(tgt));
        check("flags", 32'({bus.flag_jmp, bus.flag_rtn, bus.flag_0, bus.flag_f}),
              32'({jmpm, !sq && op == 4'hD, !sq && op == 4'h0, !sq && op == 4'hF}));
        if (r) begin
            skip_m = 1'b0;
            stk_m.delete();
        end else begin
            nskip = !skip_m && ((op == 4'hD && !popm) || (op == 4'hE && !rr_v));
            if (stacked && jmpm) begin
                stk_m.push_back(8'((int'(pc) + 1) % 256));
                if (stk_m.size() > STACK_DEPTH) void'(stk_m.pop_front());
            end
            if (popm) void'(stk_m.pop_back());
            skip_m = nskip;
        end
    endtask

    initial begin
        bus.instr = '0;
        bus.pc_in = '0;
        bus.rr    = 1'b0;
        step(1, 4'hC, 8'h05, 8'h00, 0);
        step(0, 4'hC, 8'h05, 8'h00, 0);
        check("jmp_target_const", 32'(bus.pc_target), 32'h05);
        step(0, 4'hE, 8'h00, 8'h05, 0);
        step(0, 4'h1, 8'h03, 8'h06, 0);
        check("skz_squash_const", 32'(bus.exec_en), 32'h0);
        step(0, 4'h1, 8'h03, 8'h07, 0);
        step(0, 4'hE, 8'h00, 8'h08, 1);
        step(0, 4'h1, 8'h03, 8'h09, 1);
        check("skz_pass_const", 32'({bus.exec_en, bus.io_addr}), 32'hB);
        step(0, 4'hD, 8'h00, 8'h0A, 0);
        step(0, 4'hC, 8'h40, 8'h0B, 0);
        step(0, 4'hE, 8'h00, 8'h0C, 0);
        step(0, 4'hE, 8'h00, 8'h0D, 0);
        step(0, 4'h5, 8'h02, 8'h0E, 0);
        check("skz_skz_or_const", 32'(bus.exec_en), 32'h1);
        step(0, 4'h0, 8'h00, 8'h0F, 0);
        step(0, 4'hF, 8'h00, 8'h10, 0);
        step(0, 4'h2, 8'h01, 8'hFF, 0);
        step(0, 4'hE, 8'h00, 8'h20, 0);
        step(1, 4'h1, 8'h04, 8'h21, 0);
        step(0, 4'h1, 8'h04, 8'h00, 0);
        step(1, 4'h1, 8'h00, 8'h00, 0);
        step(0, 4'hC, 8'h80, 8'h10, 0);
        step(0, 4'hD, 8'h00, 8'h85, 0);
        step(0, 4'h3, 8'h00, 8'h86, 0);
        for (int i = 0; i < 5; i++) step(0, 4'hC, 8'(8'h30 + 8'(i * 16)), 8'(8'h20 + 8'(i * 16)), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'hD, 8'h00, 8'h90, 0);
            step(0, 4'h7, 8'h05, 8'h91, 0);
        end
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 31) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
                 8'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
